// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the multi-channel single-port RAM arbiter.
// Response records carry channel/error/write flags down the read pipeline.
package sp_ram_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Channel index field is sized for the largest supported channel count.
  localparam int MAX_CH = 8;
  localparam int CH_W   = clog2(MAX_CH);

  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch_idx;
    logic            err;
    logic            we;
  } rsp_t;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: combinational one-hot grant to the first requester at/after the pointer.
// Zero latency; the pointer moves past the winner only when advance_i is high, and rst masks grants.
module rr_arb import sp_ram_pkg::*; #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] ptr_q;

  // Scan by cyclic distance from the pointer so only loop variables index the vectors.
  always_comb begin
    logic found;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int d = 0; d < N; d++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req_i[i] &&
            ((int'(ptr_q) + d == i) || (int'(ptr_q) + d == i + N))) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = IW'(i);
        end
      end
    end
    if (rst) gnt_o = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/sp_ram_mc_arb.sv
// Multi-channel single-port RAM: round-robin arbitrated access, one transfer per cycle.
// Response 1 cycle after accept (2 with OUT_REG); a requester holds req_i until granted.
module sp_ram_mc_arb import sp_ram_pkg::*; #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 15,
  parameter int NUM_WORDS  = 32768,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                req_i,
  output logic [NUM_CH-1:0]                gnt_o,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]     addr_i,
  input  logic [NUM_CH-1:0]                we_i,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0]   be_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     wdata_i,
  output logic [NUM_CH-1:0]                rvalid_o,
  output logic [NUM_CH*DATA_WIDTH-1:0]     rdata_o,
  output logic [NUM_CH-1:0]                err_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int IW       = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int MW       = (NUM_WORDS > 1) ? clog2(NUM_WORDS) : 1;

  logic [IW-1:0]         g_idx;
  logic                  acc;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [BE_WIDTH-1:0]   sel_be;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  oor;
  logic [MW-1:0]         widx;

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
  logic [DATA_WIDTH-1:0] mem_rd_q;

  rsp_t                  s1_d, s1_q, fin;
  logic [DATA_WIDTH-1:0] d1, fin_dat;
  logic                  fin_vld;

  rr_arb #(.N(NUM_CH), .IW(IW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .advance_i (acc),
    .gnt_o     (gnt_o),
    .idx_o     (g_idx)
  );

  assign acc       = |gnt_o;
  assign sel_addr  = addr_i[int'(g_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_we    = we_i[g_idx];
  assign sel_be    = be_i[int'(g_idx)*BE_WIDTH +: BE_WIDTH];
  assign sel_wdata = wdata_i[int'(g_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign oor       = 32'(sel_addr) >= 32'(NUM_WORDS);
  assign widx      = sel_addr[MW-1:0];

  // Array is not reset; out-of-range accesses never touch it.
  always_ff @(posedge clk) begin
    if (acc && !oor) begin
      if (sel_we) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (sel_be[b]) mem[widx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
        end
      end else begin
        mem_rd_q <= mem[widx];
      end
    end
  end

  always_comb begin
    s1_d        = '0;
    s1_d.valid  = acc;
    s1_d.ch_idx = CH_W'(g_idx);
    s1_d.err    = oor;
    s1_d.we     = sel_we;
  end

  always_ff @(posedge clk) begin
    if (rst) s1_q <= '0;
    else     s1_q <= s1_d;
  end

  assign d1 = (s1_q.we || s1_q.err) ? '0 : mem_rd_q;

  if (OUT_REG != 0) begin : g_oreg
    rsp_t                  s2_q;
    logic [DATA_WIDTH-1:0] s2_dat_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_q     <= '0;
        s2_dat_q <= '0;
      end else begin
        s2_q     <= s1_q;
        s2_dat_q <= d1;
      end
    end
    assign fin     = s2_q;
    assign fin_dat = s2_dat_q;
  end else begin : g_noreg
    assign fin     = s1_q;
    assign fin_dat = d1;
  end

  // Masking with rst drops a response that was already in flight when reset arrived.
  assign fin_vld = fin.valid && !rst;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DATA_WIDTH-1:0] hold_q;
    assign rvalid_o[k] = fin_vld && (fin.ch_idx == CH_W'(k));
    assign err_o[k]    = rvalid_o[k] && fin.err;
    assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rvalid_o[k] ? fin_dat : hold_q;
    always_ff @(posedge clk) begin
      if (rst)              hold_q <= '0;
      else if (rvalid_o[k]) hold_q <= fin_dat;
    end
  end

endmodule
